// File: rtl/memory_port_arbiter_if.sv
// Bundle of pipeline-side request/response signals and memory-controller signals
// shared by the memory port arbiter and whatever drives it.
interface memory_port_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             fetch_enable;
    logic [WIDTH-1:0] fetch_address;
    logic             fetch_valid;
    logic [WIDTH-1:0] fetch_data;

    logic             read_enable;
    logic [WIDTH-1:0] read_address;
    logic             read_valid;
    logic [WIDTH-1:0] read_data;

    logic             write_enable;
    logic [WIDTH-1:0] write_address;
    logic [WIDTH-1:0] write_value;
    logic             write_done;

    logic             mem_read_enable;
    logic             mem_write_enable;
    logic [WIDTH-1:0] mem_address;
    logic [WIDTH-1:0] mem_write_data;
    logic             mem_ready;
    logic [WIDTH-1:0] mem_read_data;

    // Arbiter view
    modport slave (
        input  fetch_enable, fetch_address,
        output fetch_valid, fetch_data,
        input  read_enable, read_address,
        output read_valid, read_data,
        input  write_enable, write_address, write_value,
        output write_done,
        output mem_read_enable, mem_write_enable, mem_address, mem_write_data,
        input  mem_ready, mem_read_data
    );

    // Pipeline and memory-controller view
    modport master (
        output fetch_enable, fetch_address,
        input  fetch_valid, fetch_data,
        output read_enable, read_address,
        input  read_valid, read_data,
        output write_enable, write_address, write_value,
        input  write_done,
        input  mem_read_enable, mem_write_enable, mem_address, mem_write_data,
        output mem_ready, mem_read_data
    );
endinterface

// File: rtl/memory_port_arbiter.sv
// Shares one memory port between fetch, load and store requesters: one access in
// flight, write > read > fetch priority, fetch forced after repeated lost grants.
module memory_port_arbiter #(
    parameter int WIDTH              = 32,
    parameter int FETCH_STARVE_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    memory_port_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;
    typedef enum logic [1:0] {OWN_FETCH, OWN_READ, OWN_WRITE} owner_t;

    localparam logic [3:0] LIMIT = 4'(FETCH_STARVE_LIMIT);

    state_t           r_state, w_state_nx;
    owner_t           r_owner, w_owner_nx;
    logic [3:0]       r_starve, w_starve_nx;
    logic             r_mem_rd, w_mem_rd_nx;
    logic             r_mem_wr, w_mem_wr_nx;
    logic [WIDTH-1:0] r_mem_addr, w_mem_addr_nx;
    logic [WIDTH-1:0] r_mem_wdata, w_mem_wdata_nx;
    logic             r_fetch_valid, w_fetch_valid_nx;
    logic             r_read_valid, w_read_valid_nx;
    logic             r_write_done, w_write_done_nx;
    logic [WIDTH-1:0] r_fetch_data, w_fetch_data_nx;
    logic [WIDTH-1:0] r_read_data, w_read_data_nx;

    logic w_any_req;
    logic w_fetch_forced;

    assign w_any_req      = bus.fetch_enable | bus.read_enable | bus.write_enable;
    assign w_fetch_forced = (r_starve == LIMIT) && bus.fetch_enable;

    always_comb begin
        w_state_nx       = r_state;
        w_owner_nx       = r_owner;
        w_starve_nx      = r_starve;
        w_mem_rd_nx      = r_mem_rd;
        w_mem_wr_nx      = r_mem_wr;
        w_mem_addr_nx    = r_mem_addr;
        w_mem_wdata_nx   = r_mem_wdata;
        w_fetch_valid_nx = 1'b0;
        w_read_valid_nx  = 1'b0;
        w_write_done_nx  = 1'b0;
        w_fetch_data_nx  = r_fetch_data;
        w_read_data_nx   = r_read_data;

        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nx = ST_BUSY;
                    if (w_fetch_forced)        w_owner_nx = OWN_FETCH;
                    else if (bus.write_enable) w_owner_nx = OWN_WRITE;
                    else if (bus.read_enable)  w_owner_nx = OWN_READ;
                    else                       w_owner_nx = OWN_FETCH;

                    case (w_owner_nx)
                        OWN_WRITE: begin
                            w_mem_wr_nx    = 1'b1;
                            w_mem_addr_nx  = bus.write_address;
                            w_mem_wdata_nx = bus.write_value;
                        end
                        OWN_READ: begin
                            w_mem_rd_nx   = 1'b1;
                            w_mem_addr_nx = bus.read_address;
                        end
                        default: begin
                            w_mem_rd_nx   = 1'b1;
                            w_mem_addr_nx = bus.fetch_address;
                        end
                    endcase

                    // A lost arbitration only counts while fetch is actually waiting
                    if (w_owner_nx == OWN_FETCH)
                        w_starve_nx = 4'd0;
                    else if (bus.fetch_enable && (r_starve < LIMIT))
                        w_starve_nx = r_starve + 4'd1;
                end
            end
            ST_BUSY: begin
                if (bus.mem_ready) begin
                    w_state_nx  = ST_DONE;
                    w_mem_rd_nx = 1'b0;
                    w_mem_wr_nx = 1'b0;
                    case (r_owner)
                        OWN_FETCH: begin
                            w_fetch_valid_nx = 1'b1;
                            w_fetch_data_nx  = bus.mem_read_data;
                        end
                        OWN_READ: begin
                            w_read_valid_nx = 1'b1;
                            w_read_data_nx  = bus.mem_read_data;
                        end
                        default: w_write_done_nx = 1'b1;
                    endcase
                end
            end
            ST_DONE: w_state_nx = ST_IDLE;
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_owner       <= OWN_FETCH;
            r_starve      <= 4'd0;
            r_mem_rd      <= 1'b0;
            r_mem_wr      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_fetch_valid <= 1'b0;
            r_read_valid  <= 1'b0;
            r_write_done  <= 1'b0;
            r_fetch_data  <= '0;
            r_read_data   <= '0;
        end else begin
            r_state       <= w_state_nx;
            r_owner       <= w_owner_nx;
            r_starve      <= w_starve_nx;
            r_mem_rd      <= w_mem_rd_nx;
            r_mem_wr      <= w_mem_wr_nx;
            r_mem_addr    <= w_mem_addr_nx;
            r_mem_wdata   <= w_mem_wdata_nx;
            r_fetch_valid <= w_fetch_valid_nx;
            r_read_valid  <= w_read_valid_nx;
            r_write_done  <= w_write_done_nx;
            r_fetch_data  <= w_fetch_data_nx;
            r_read_data   <= w_read_data_nx;
        end
    end

    assign bus.mem_read_enable  = r_mem_rd;
    assign bus.mem_write_enable = r_mem_wr;
    assign bus.mem_address      = r_mem_addr;
    assign bus.mem_write_data   = r_mem_wdata;
    assign bus.fetch_valid      = r_fetch_valid;
    assign bus.fetch_data       = r_fetch_data;
    assign bus.read_valid       = r_read_valid;
    assign bus.read_data        = r_read_data;
    assign bus.write_done       = r_write_done;
endmodule

// File: tb/tb_memory_port_arbiter.sv
// Bench for memory_port_arbiter: directed scenarios plus random traffic, all
// checked against a transaction-level model and a behavioural memory.
module tb_memory_port_arbiter;
    localparam int W     = 32;
    localparam int LIMIT = 2;
    localparam int OW_F  = 1;
    localparam int OW_R  = 2;
    localparam int OW_W  = 3;

    logic clock;
    logic reset_n;

    memory_port_arbiter_if #(.WIDTH(W)) bus ();

    memory_port_arbiter #(.WIDTH(W), .FETCH_STARVE_LIMIT(LIMIT)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %h, required %h", tag, obs, exp);
    endtask

    logic [W-1:0] mem [logic [W-1:0]];

    function automatic logic [W-1:0] mem_load(input logic [W-1:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [W-1:0] raddr();
        return W'($urandom_range(0, 15)) << 2;
    endfunction

    // Transaction model: one open access at a time, grant decided from the
    // enables presented in a cycle where the port was free.
    bit           m_open, m_free;
    int           m_owner, m_pulse, m_starve, m_wait, m_lat;
    logic [W-1:0] m_addr, m_wdata, m_sup, e_fdata, e_rdata;
    int           grant_log[$];
    int           done_log[$];
    int           cnt_fv, cnt_rv, cnt_wd, cnt_rd100, cnt_both;
    bit           rand_mode, rand_lat, noise;
    int           fixed_lat;
    bit           keep_f, keep_r, keep_w;

    task automatic model_init();
        m_open = 0; m_free = 1; m_owner = 0; m_pulse = 0; m_starve = 0;
        m_wait = 0; m_lat = 1; m_addr = '0; m_wdata = '0; m_sup = '0;
        e_fdata = '0; e_rdata = '0;
        grant_log.delete(); done_log.delete();
        cnt_fv = 0; cnt_rv = 0; cnt_wd = 0; cnt_rd100 = 0; cnt_both = 0;
    endtask

    task automatic evaluate();
        bit fen, ren, wen, rdy;
        fen = bus.fetch_enable; ren = bus.read_enable; wen = bus.write_enable;
        rdy = bus.mem_ready;
        m_pulse = 0;
        if (m_open && rdy) begin
            m_pulse = m_owner;
            m_open  = 0;
            done_log.push_back(m_owner);
            if (m_owner == OW_F) e_fdata = m_sup;
            else if (m_owner == OW_R) e_rdata = m_sup;
        end else if (!m_open && m_free && (fen || ren || wen)) begin
            int win;
            if (fen && m_starve == LIMIT) win = OW_F;
            else if (wen)                 win = OW_W;
            else if (ren)                 win = OW_R;
            else                          win = OW_F;
            if (win == OW_F) m_starve = 0;
            else if (fen && m_starve < LIMIT) m_starve++;
            m_owner = win;
            m_addr  = (win == OW_F) ? bus.fetch_address :
                      (win == OW_R) ? bus.read_address : bus.write_address;
            m_wdata = bus.write_value;
            m_open  = 1;
            m_wait  = 0;
            m_lat   = rand_lat ? int'($urandom_range(1, 3)) : fixed_lat;
            grant_log.push_back(win);
        end
        m_free = !m_open && (m_pulse == 0);

        check("mem_rd_strobe", W'(bus.mem_read_enable), W'(m_open && m_owner != OW_W));
        check("mem_wr_strobe", W'(bus.mem_write_enable), W'(m_open && m_owner == OW_W));
        if (m_open) check("mem_address", bus.mem_address, m_addr);
        if (m_open && m_owner == OW_W) check("mem_write_data", bus.mem_write_data, m_wdata);
        check("fetch_valid", W'(bus.fetch_valid), W'(m_pulse == OW_F));
        check("read_valid", W'(bus.read_valid), W'(m_pulse == OW_R));
        check("write_done", W'(bus.write_done), W'(m_pulse == OW_W));
        check("fetch_data", bus.fetch_data, e_fdata);
        check("read_data", bus.read_data, e_rdata);

        if (bus.fetch_valid) cnt_fv++;
        if (bus.read_valid)  cnt_rv++;
        if (bus.write_done)  cnt_wd++;
        if (bus.mem_read_enable && bus.mem_address == 32'h100) cnt_rd100++;
        if (bus.mem_read_enable && bus.mem_write_enable) cnt_both++;
    endtask

    task automatic drive();
        bus.mem_ready     = 1'b0;
        bus.mem_read_data = $urandom;
        if (m_open) begin
            m_wait++;
            if (m_wait >= m_lat) begin
                bus.mem_ready = 1'b1;
                if (m_owner == OW_W) begin
                    mem[bus.mem_address] = bus.mem_write_data;
                end else begin
                    m_sup = mem_load(bus.mem_address);
                    bus.mem_read_data = m_sup;
                end
            end
        end else if (noise) begin
            bus.mem_ready = ($urandom_range(0, 3) == 0);
        end

        if (m_pulse == OW_F) begin
            if (!keep_f && !(rand_mode && $urandom_range(0, 1) == 1)) bus.fetch_enable = 1'b0;
            else if (rand_mode) bus.fetch_address = raddr();
        end
        if (m_pulse == OW_R) begin
            if (!keep_r && !(rand_mode && $urandom_range(0, 1) == 1)) bus.read_enable = 1'b0;
            else if (rand_mode) bus.read_address = raddr();
        end
        if (m_pulse == OW_W) begin
            if (!keep_w && !(rand_mode && $urandom_range(0, 1) == 1)) bus.write_enable = 1'b0;
            else if (rand_mode) begin
                bus.write_address = raddr();
                bus.write_value   = $urandom;
            end
        end

        if (rand_mode) begin
            if (!bus.fetch_enable) begin
                if ($urandom_range(0, 2) == 0) begin
                    bus.fetch_enable = 1'b1; bus.fetch_address = raddr();
                end
            end else if ($urandom_range(0, 9) == 0) bus.fetch_address = raddr();
            if (!bus.read_enable) begin
                if ($urandom_range(0, 3) == 0) begin
                    bus.read_enable = 1'b1; bus.read_address = raddr();
                end
            end else if ($urandom_range(0, 9) == 0) bus.read_address = raddr();
            if (!bus.write_enable) begin
                if ($urandom_range(0, 3) == 0) begin
                    bus.write_enable = 1'b1; bus.write_address = raddr();
                    bus.write_value = $urandom;
                end
            end else if ($urandom_range(0, 9) == 0) bus.write_value = $urandom;
        end
    endtask

    task automatic cycle();
        @(negedge clock);
        evaluate();
        drive();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic check_zero();
        check("rst_mem_rd", W'(bus.mem_read_enable), '0);
        check("rst_mem_wr", W'(bus.mem_write_enable), '0);
        check("rst_mem_addr", bus.mem_address, '0);
        check("rst_mem_wdata", bus.mem_write_data, '0);
        check("rst_pulses", W'({bus.fetch_valid, bus.read_valid, bus.write_done}), '0);
        check("rst_fetch_data", bus.fetch_data, '0);
        check("rst_read_data", bus.read_data, '0);
    endtask

    // Assert reset part-way through a cycle so the asynchronous path is exercised
    task automatic do_reset();
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        bus.fetch_enable = 1'b0; bus.read_enable = 1'b0; bus.write_enable = 1'b0;
        bus.fetch_address = '0; bus.read_address = '0; bus.write_address = '0;
        bus.write_value = '0; bus.mem_ready = 1'b0; bus.mem_read_data = '0;
        keep_f = 0; keep_r = 0; keep_w = 0; rand_mode = 0;
        #1 check_zero();
        model_init();
        repeat (2) @(negedge clock);
        check_zero();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b1;
        noise = 1; rand_lat = 0; fixed_lat = 1;
        model_init();

        // Reset in the middle of a long access, then a plain load
        do_reset();
        fixed_lat = 5;
        bus.read_enable = 1'b1; bus.read_address = 32'h111;
        run(2);
        check("busy_before_reset", W'(bus.mem_read_enable), 32'd1);
        do_reset();
        run(4);
        check("no_pulse_after_abort", W'(cnt_fv + cnt_rv + cnt_wd), 32'd0);
        mem[32'h100] = 32'hDEADBEEF;
        fixed_lat = 2;
        bus.read_enable = 1'b1; bus.read_address = 32'h100;
        run(8);
        check("load_strobe_cycles", W'(cnt_rd100), 32'd2);
        check("load_pulse_count", W'(cnt_rv), 32'd1);
        check("load_data", bus.read_data, 32'hDEADBEEF);
        check("load_other_pulses", W'(cnt_fv + cnt_wd), 32'd0);

        // All three requesters at once
        do_reset();
        fixed_lat = 1;
        bus.write_enable = 1'b1; bus.write_address = 32'h20; bus.write_value = 32'h55;
        bus.read_enable  = 1'b1; bus.read_address  = 32'h40;
        bus.fetch_enable = 1'b1; bus.fetch_address = 32'h0;
        run(12);
        check("simul_count", W'(done_log.size()), 32'd3);
        check("simul_first", W'(done_log[0]), W'(OW_W));
        check("simul_second", W'(done_log[1]), W'(OW_R));
        check("simul_third", W'(done_log[2]), W'(OW_F));
        check("simul_stored", mem_load(32'h20), 32'h55);

        // Fetch starvation with continuously re-asserted stores and loads
        do_reset();
        fixed_lat = 1;
        keep_f = 1; keep_r = 1; keep_w = 1;
        bus.write_enable = 1'b1; bus.write_address = 32'h8; bus.write_value = 32'h1234;
        bus.read_enable  = 1'b1; bus.read_address  = 32'hC;
        bus.fetch_enable = 1'b1; bus.fetch_address = 32'h4;
        run(19);
        check("starve_grant0", W'(grant_log[0]), W'(OW_W));
        check("starve_grant1", W'(grant_log[1]), W'(OW_W));
        check("starve_grant2", W'(grant_log[2]), W'(OW_F));
        check("starve_grant3", W'(grant_log[3]), W'(OW_W));
        check("starve_grant4", W'(grant_log[4]), W'(OW_W));
        check("starve_grant5", W'(grant_log[5]), W'(OW_F));
        keep_f = 0; keep_r = 0; keep_w = 0;
        run(15);

        // Requester address changes after grant are ignored
        do_reset();
        fixed_lat = 3;
        bus.read_enable = 1'b1; bus.read_address = 32'h100;
        cycle();
        check("held_addr_0", bus.mem_address, 32'h100);
        bus.read_address = 32'h200;
        cycle();
        check("held_addr_1", bus.mem_address, 32'h100);
        cycle();
        check("held_addr_2", bus.mem_address, 32'h100);
        run(4);
        check("held_pulse_count", W'(cnt_rv), 32'd1);

        // Back-to-back loads from one requester
        do_reset();
        fixed_lat = 1;
        keep_r = 1;
        bus.read_enable = 1'b1; bus.read_address = 32'h80;
        run(6);
        check("b2b_pulses", W'(cnt_rv), 32'd2);
        check("b2b_grants", W'(grant_log.size()), 32'd2);
        keep_r = 0;
        run(6);

        // Random traffic with random memory latency and stray mem_ready
        do_reset();
        rand_lat = 1;
        rand_mode = 1;
        run(10000);
        rand_mode = 0;
        run(60);
        check("rand_grants_eq_pulses", W'(grant_log.size()), W'(done_log.size()));
        check("rand_enough_grants", W'(grant_log.size() > 1000), 32'd1);
        check("rand_strobe_exclusive", W'(cnt_both), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
